// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg: shared types and constants for the reservation-station queue.
//   TAG_NONE        - ROB tag value meaning "no dependency / operand ready".
//   rs_operand_t    - {producer tag, captured value} for one source operand.
//   rs_entry_t      - one RS slot: valid, dest tag, command, two operands.
//   capture_operand - builds a stored operand from dispatch inputs, including
//                     the same-cycle CDB collision capture.
// Struct widths follow the package localparams; the rs_queue defaults use
// the same values.
// ---------------------------------------------------------------------------
package rs_pkg;

  localparam int RS_DATA_W   = 64;
  localparam int RS_CMD_W    = 10;
  localparam int OPCODE_W    = RS_CMD_W;
  localparam int RS_ROB_SIZE = 32;
  localparam int RS_TAG_W    = $clog2(RS_ROB_SIZE + 1);

  localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic [RS_TAG_W-1:0]  tag;
    logic [RS_DATA_W-1:0] value;
  } rs_operand_t;

  typedef struct packed {
    logic                valid;
    logic [RS_TAG_W-1:0] dest;
    logic [RS_CMD_W-1:0] cmd;
    rs_operand_t         src1;
    rs_operand_t         src2;
  } rs_entry_t;

  // A value-valid operand is ready immediately. A pending operand whose
  // producer is broadcasting in the dispatch cycle is captured from the CDB,
  // otherwise it would miss its only wakeup.
  function automatic rs_operand_t capture_operand(
    input logic [RS_DATA_W:0]   disp_val,
    input logic [RS_TAG_W-1:0]  disp_tag,
    input logic                 cdb_valid,
    input logic [RS_TAG_W-1:0]  cdb_tag,
    input logic [RS_DATA_W-1:0] cdb_val
  );
    rs_operand_t op;
    op.value = disp_val[RS_DATA_W-1:0];
    op.tag   = disp_tag;
    if (disp_val[RS_DATA_W]) begin
      op.tag = TAG_NONE;
    end else if (cdb_valid && (disp_tag != TAG_NONE) && (cdb_tag == disp_tag)) begin
      op.tag   = TAG_NONE;
      op.value = cdb_val;
    end
    return op;
  endfunction

endpackage

// File: rtl/rs_queue_if.sv
// ---------------------------------------------------------------------------
// rs_queue_if: dispatch, CDB broadcast and issue signals of rs_queue.
//   master - decode/CDB/FU side (drives dispatch, CDB and iss_ready_i).
//   slave  - the reservation station.
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high. disp_ready_o and iss_valid_o never depend on the partner's
// valid/ready in the same cycle; a presented issue entry stays presented
// while iss_ready_i is low unless an older entry becomes ready.
// ---------------------------------------------------------------------------
interface rs_queue_if #(
  parameter int DATA_W = rs_pkg::RS_DATA_W,
  parameter int CMD_W  = rs_pkg::RS_CMD_W,
  parameter int TAG_W  = rs_pkg::RS_TAG_W
);
  logic              disp_valid_i;
  logic              disp_ready_o;
  logic [TAG_W-1:0]  disp_tag_i;
  logic [TAG_W-1:0]  disp_src1_tag_i;
  logic [TAG_W-1:0]  disp_src2_tag_i;
  logic [DATA_W:0]   disp_src1_val_i;
  logic [DATA_W:0]   disp_src2_val_i;
  logic [CMD_W-1:0]  disp_cmd_i;

  logic              cdb_valid_i;
  logic [TAG_W-1:0]  cdb_tag_i;
  logic [DATA_W-1:0] cdb_val_i;

  logic              iss_valid_o;
  logic              iss_ready_i;
  logic [DATA_W-1:0] iss_src1_o;
  logic [DATA_W-1:0] iss_src2_o;
  logic [CMD_W-1:0]  iss_cmd_o;
  logic [TAG_W-1:0]  iss_tag_o;

  modport master (
    output disp_valid_i, disp_tag_i, disp_src1_tag_i, disp_src2_tag_i,
           disp_src1_val_i, disp_src2_val_i, disp_cmd_i,
           cdb_valid_i, cdb_tag_i, cdb_val_i, iss_ready_i,
    input  disp_ready_o, iss_valid_o, iss_src1_o, iss_src2_o, iss_cmd_o, iss_tag_o
  );

  modport slave (
    input  disp_valid_i, disp_tag_i, disp_src1_tag_i, disp_src2_tag_i,
           disp_src1_val_i, disp_src2_val_i, disp_cmd_i,
           cdb_valid_i, cdb_tag_i, cdb_val_i, iss_ready_i,
    output disp_ready_o, iss_valid_o, iss_src1_o, iss_src2_o, iss_cmd_o, iss_tag_o
  );
endinterface

// File: rtl/rs_age_select.sv
// ---------------------------------------------------------------------------
// rs_age_select: picks the oldest ready entry.
//   older [i][j] - entry i was dispatched before entry j.
//   ready [i]    - entry i may issue.
//   grant        - one-hot oldest ready entry, zero when nothing is ready.
// An entry is granted when no other ready entry is older than it. The age
// relation between live entries is a strict total order, so at most one
// grant bit is set.
// ---------------------------------------------------------------------------
module rs_age_select #(
  parameter int ENTRIES = 4
) (
  input  logic [ENTRIES-1:0][ENTRIES-1:0] older,
  input  logic [ENTRIES-1:0]              ready,
  output logic [ENTRIES-1:0]              grant
);

  always_comb begin
    grant = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if ((j != i) && ready[j] && older[j][i]) begin
          grant[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rs_queue.sv
// ---------------------------------------------------------------------------
// rs_queue: multi-entry reservation station for one functional-unit class.
//   clk_i, reset_i - clock, asynchronous active-high reset.
//   flush_i        - synchronous clear of every entry (beats dispatch).
//   bus            - rs_queue_if.slave: dispatch, CDB broadcast, issue.
//   occupancy_o    - number of valid entries.
// Dispatch writes the lowest free slot; CDB broadcasts wake matching
// operands; the oldest entry with both operands ready is issued.
// Optional feature, macro RS_CDB_BYPASS_EN: an entry whose last pending
// operand matches the current CDB broadcast is selectable in that same
// cycle with cdb_val_i forwarded onto the issue operands. Without the
// macro, selection uses registered state only.
// ---------------------------------------------------------------------------
module rs_queue
  import rs_pkg::*;
#(
  parameter int ENTRIES  = 4,
  parameter int DATA_W   = RS_DATA_W,
  parameter int CMD_W    = OPCODE_W,
  parameter int ROB_SIZE = RS_ROB_SIZE,
  parameter int TAG_W    = $clog2(ROB_SIZE + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  rs_queue_if.slave                    bus,
  output logic [$clog2(ENTRIES+1)-1:0] occupancy_o
);

  localparam int OCC_W = $clog2(ENTRIES + 1);

  rs_entry_t                      entries_q [ENTRIES];
  // older_q[i][j]: entry i was dispatched before entry j.
  logic [ENTRIES-1:0][ENTRIES-1:0] older_q;

  logic [ENTRIES-1:0] valid_vec;
  logic [ENTRIES-1:0] wake1;
  logic [ENTRIES-1:0] wake2;
  logic [ENTRIES-1:0] ready_vec;
  logic [ENTRIES-1:0] free_onehot;
  logic [ENTRIES-1:0] iss_onehot;

  logic               cdb_hit_en;
  logic               disp_ready;
  logic               disp_fire;
  logic               iss_valid;
  logic               iss_fire;
  rs_entry_t          disp_entry;

  logic [TAG_W-1:0]   sel_tag;
  logic [CMD_W-1:0]   sel_cmd;
  logic [DATA_W-1:0]  sel_src1;
  logic [DATA_W-1:0]  sel_src2;
  logic [OCC_W-1:0]   occ;

  // Tag 0 means "no producer", so a broadcast of tag 0 wakes nothing.
  assign cdb_hit_en = bus.cdb_valid_i && (bus.cdb_tag_i != TAG_NONE);

  always_comb begin
    valid_vec = '0;
    wake1     = '0;
    wake2     = '0;
    ready_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      wake1[i] = entries_q[i].valid && cdb_hit_en && (entries_q[i].src1.tag == bus.cdb_tag_i);
      wake2[i] = entries_q[i].valid && cdb_hit_en && (entries_q[i].src2.tag == bus.cdb_tag_i);
`ifdef RS_CDB_BYPASS_EN
      ready_vec[i] = entries_q[i].valid
        && ((entries_q[i].src1.tag == TAG_NONE) || (cdb_hit_en && (entries_q[i].src1.tag == bus.cdb_tag_i)))
        && ((entries_q[i].src2.tag == TAG_NONE) || (cdb_hit_en && (entries_q[i].src2.tag == bus.cdb_tag_i)));
`else
      ready_vec[i] = entries_q[i].valid
        && (entries_q[i].src1.tag == TAG_NONE)
        && (entries_q[i].src2.tag == TAG_NONE);
`endif
    end
  end

  // Adding 1 turns the lowest clear bit of valid_vec into the only bit that
  // survives masking with ~valid_vec: lowest free slot, one-hot.
  assign free_onehot = ~valid_vec & (valid_vec + ENTRIES'(1));

  assign disp_ready = ~&valid_vec;
  assign disp_fire  = bus.disp_valid_i && disp_ready && !flush_i;
  assign iss_valid  = |ready_vec;
  assign iss_fire   = iss_valid && bus.iss_ready_i;

  rs_age_select #(.ENTRIES(ENTRIES)) u_age_select (
    .older (older_q),
    .ready (ready_vec),
    .grant (iss_onehot)
  );

  always_comb begin
    disp_entry       = '0;
    disp_entry.valid = 1'b1;
    disp_entry.dest  = bus.disp_tag_i;
    disp_entry.cmd   = bus.disp_cmd_i;
    disp_entry.src1  = capture_operand(bus.disp_src1_val_i, bus.disp_src1_tag_i,
                                       bus.cdb_valid_i, bus.cdb_tag_i, bus.cdb_val_i);
    disp_entry.src2  = capture_operand(bus.disp_src2_val_i, bus.disp_src2_tag_i,
                                       bus.cdb_valid_i, bus.cdb_tag_i, bus.cdb_val_i);
  end

  // Issue mux; all-zero when no entry is granted.
  always_comb begin
    sel_tag  = '0;
    sel_cmd  = '0;
    sel_src1 = '0;
    sel_src2 = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (iss_onehot[i]) begin
        sel_tag  = entries_q[i].dest;
        sel_cmd  = entries_q[i].cmd;
        sel_src1 = entries_q[i].src1.value;
        sel_src2 = entries_q[i].src2.value;
`ifdef RS_CDB_BYPASS_EN
        // A granted entry with a pending tag can only be waiting on the
        // current broadcast, so forward it.
        if (entries_q[i].src1.tag != TAG_NONE) sel_src1 = bus.cdb_val_i;
        if (entries_q[i].src2.tag != TAG_NONE) sel_src2 = bus.cdb_val_i;
`endif
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      occ = occ + OCC_W'(valid_vec[i]);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
      older_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        // The dispatch slot is free in registered state, so it is never
        // the issuing entry nor a wakeup target.
        if (disp_fire && free_onehot[i]) begin
          entries_q[i] <= disp_entry;
          // Newest entry: younger than every other slot.
          for (int j = 0; j < ENTRIES; j++) begin
            older_q[i][j] <= 1'b0;
            older_q[j][i] <= (i != j);
          end
        end else begin
          if (iss_fire && iss_onehot[i]) begin
            entries_q[i].valid <= 1'b0;
          end
          if (wake1[i]) begin
            entries_q[i].src1.tag   <= TAG_NONE;
            entries_q[i].src1.value <= bus.cdb_val_i;
          end
          if (wake2[i]) begin
            entries_q[i].src2.tag   <= TAG_NONE;
            entries_q[i].src2.value <= bus.cdb_val_i;
          end
        end
      end
    end
  end

  assign bus.disp_ready_o = disp_ready;
  assign bus.iss_valid_o  = iss_valid;
  assign bus.iss_tag_o    = sel_tag;
  assign bus.iss_cmd_o    = sel_cmd;
  assign bus.iss_src1_o   = sel_src1;
  assign bus.iss_src2_o   = sel_src2;
  assign occupancy_o      = occ;

endmodule

// File: tb/tb_rs_queue.sv
// ---------------------------------------------------------------------------
// tb_rs_queue: self-checking bench for rs_queue (ENTRIES=4, defaults).
// The reference is an age-ordered queue of live ops; each negative edge the
// DUT outputs are compared against it, and directed sequences pin known
// literal results. Build with +define+RS_CDB_BYPASS_EN to check the bypass.
// ---------------------------------------------------------------------------
module tb_rs_queue;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int CW = 10;
  localparam int TW = 6;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       flush_i;
  logic [2:0] occ;

  int tests  = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  rs_queue_if #(.DATA_W(DW), .CMD_W(CW), .TAG_W(TW)) rsif ();

  rs_queue #(.ENTRIES(N), .DATA_W(DW), .CMD_W(CW), .ROB_SIZE(32), .TAG_W(TW)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .bus         (rsif),
    .occupancy_o (occ)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [TW-1:0] dest;
    logic [CW-1:0] cmd;
    logic [TW-1:0] t1;
    logic [TW-1:0] t2;
    logic [DW-1:0] v1;
    logic [DW-1:0] v2;
  } m_ent_t;

  m_ent_t mq[$];  // live ops, oldest first

  function automatic bit op_ready(input logic [TW-1:0] t);
    if (t == '0) return 1'b1;
`ifdef RS_CDB_BYPASS_EN
    return rsif.cdb_valid_i && (rsif.cdb_tag_i == t);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] op_val(input logic [TW-1:0] t, input logic [DW-1:0] v);
    return (t == '0) ? v : rsif.cdb_val_i;
  endfunction

  function automatic int pick();
    for (int i = 0; i < mq.size(); i++) begin
      if (op_ready(mq[i].t1) && op_ready(mq[i].t2)) return i;
    end
    return -1;
  endfunction

  task automatic capture(input logic [DW:0] sv, input logic [TW-1:0] st,
                         output logic [TW-1:0] t, output logic [DW-1:0] v);
    t = st;
    v = sv[DW-1:0];
    if (sv[DW]) t = '0;
    else if (rsif.cdb_valid_i && st != '0 && rsif.cdb_tag_i == st) begin
      t = '0;
      v = rsif.cdb_val_i;
    end
  endtask

  // Advance the model by one clock edge using the inputs held this cycle.
  task automatic model_step();
    int p;
    bit full;
    m_ent_t e;
    if (reset_i || flush_i) begin
      mq.delete();
      return;
    end
    p    = pick();
    full = (mq.size() >= N);
    if (p >= 0 && rsif.iss_ready_i) mq.delete(p);
    if (rsif.cdb_valid_i && rsif.cdb_tag_i != '0) begin
      foreach (mq[i]) begin
        e = mq[i];
        if (e.t1 == rsif.cdb_tag_i) begin e.t1 = '0; e.v1 = rsif.cdb_val_i; end
        if (e.t2 == rsif.cdb_tag_i) begin e.t2 = '0; e.v2 = rsif.cdb_val_i; end
        mq[i] = e;
      end
    end
    if (rsif.disp_valid_i && !full) begin
      e.dest = rsif.disp_tag_i;
      e.cmd  = rsif.disp_cmd_i;
      capture(rsif.disp_src1_val_i, rsif.disp_src1_tag_i, e.t1, e.v1);
      capture(rsif.disp_src2_val_i, rsif.disp_src2_tag_i, e.t2, e.v2);
      mq.push_back(e);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    int p;
    logic          e_valid = 1'b0;
    logic          e_rdy   = 1'b1;
    logic [TW-1:0] e_tag   = '0;
    logic [CW-1:0] e_cmd   = '0;
    logic [DW-1:0] e_s1    = '0;
    logic [DW-1:0] e_s2    = '0;
    int            e_occ   = 0;
    if (!reset_i) begin
      p     = pick();
      e_rdy = (mq.size() < N);
      e_occ = mq.size();
      if (p >= 0) begin
        e_valid = 1'b1;
        e_tag   = mq[p].dest;
        e_cmd   = mq[p].cmd;
        e_s1    = op_val(mq[p].t1, mq[p].v1);
        e_s2    = op_val(mq[p].t2, mq[p].v2);
      end
    end
    check("cyc_disp_ready", 64'(rsif.disp_ready_o), 64'(e_rdy));
    check("cyc_occupancy",  64'(occ),               64'(e_occ));
    check("cyc_iss_valid",  64'(rsif.iss_valid_o),  64'(e_valid));
    check("cyc_iss_tag",    64'(rsif.iss_tag_o),    64'(e_tag));
    check("cyc_iss_cmd",    64'(rsif.iss_cmd_o),    64'(e_cmd));
    check("cyc_iss_src1",   rsif.iss_src1_o,        e_s1);
    check("cyc_iss_src2",   rsif.iss_src2_o,        e_s2);
  endtask

  always @(negedge clk) if (chk_en) compare_outputs();

  // ---------------- driver tasks ----------------
  function automatic logic [DW:0] vv(input logic [DW-1:0] v);
    return {1'b1, v};
  endfunction

  task automatic set_idle();
    rsif.disp_valid_i    = 1'b0;
    rsif.disp_tag_i      = '0;
    rsif.disp_src1_tag_i = '0;
    rsif.disp_src2_tag_i = '0;
    rsif.disp_src1_val_i = '0;
    rsif.disp_src2_val_i = '0;
    rsif.disp_cmd_i      = '0;
    rsif.cdb_valid_i     = 1'b0;
    rsif.cdb_tag_i       = '0;
    rsif.cdb_val_i       = '0;
    rsif.iss_ready_i     = 1'b1;
    flush_i              = 1'b0;
  endtask

  task automatic dispatch(input logic [TW-1:0] dest, input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                          input logic [DW:0] s1, input logic [DW:0] s2, input logic [CW-1:0] cmd);
    rsif.disp_valid_i    = 1'b1;
    rsif.disp_tag_i      = dest;
    rsif.disp_src1_tag_i = t1;
    rsif.disp_src2_tag_i = t2;
    rsif.disp_src1_val_i = s1;
    rsif.disp_src2_val_i = s2;
    rsif.disp_cmd_i      = cmd;
  endtask

  task automatic cdb(input logic [TW-1:0] t, input logic [DW-1:0] v);
    rsif.cdb_valid_i = 1'b1;
    rsif.cdb_tag_i   = t;
    rsif.cdb_val_i   = v;
  endtask

  // Compare at the negedge, update the model, then land 1 unit after the edge.
  task automatic tick();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_disp_ready", 64'(rsif.disp_ready_o), 64'd1);
    check("rst_iss_valid",  64'(rsif.iss_valid_o),  64'd0);
    check("rst_occupancy",  64'(occ),               64'd0);
    check("rst_iss_src1",   rsif.iss_src1_o,        64'd0);
    reset_i = 1'b0;

    // Both operands valid: issue one cycle after dispatch.
    dispatch(6'd3, 6'd0, 6'd0, vv(64'hA), vv(64'hB), 10'h11);
    tick(); set_idle();
    check("t1_valid", 64'(rsif.iss_valid_o), 64'd1);
    check("t1_src1",  rsif.iss_src1_o,       64'hA);
    check("t1_src2",  rsif.iss_src2_o,       64'hB);
    check("t1_tag",   64'(rsif.iss_tag_o),   64'd3);
    check("t1_cmd",   64'(rsif.iss_cmd_o),   64'h11);
    tick();
    check("t1_occ_after", 64'(occ), 64'd0);

    // Two pending sources woken by successive broadcasts.
    dispatch(6'd6, 6'd4, 6'd5, '0, '0, 10'h22);
    rsif.iss_ready_i = 1'b0;
    tick(); set_idle(); rsif.iss_ready_i = 1'b0;
    check("t2_wait0", 64'(rsif.iss_valid_o), 64'd0);
    cdb(6'd4, 64'hC);
    tick(); set_idle(); rsif.iss_ready_i = 1'b0;
    check("t2_wait1", 64'(rsif.iss_valid_o), 64'd0);
    cdb(6'd5, 64'hD);
`ifdef RS_CDB_BYPASS_EN
    #1;
    check("byp_valid", 64'(rsif.iss_valid_o), 64'd1);
    check("byp_src1",  rsif.iss_src1_o,       64'hC);
    check("byp_src2",  rsif.iss_src2_o,       64'hD);
`endif
    tick(); set_idle(); rsif.iss_ready_i = 1'b0;
    check("t2_valid", 64'(rsif.iss_valid_o), 64'd1);
    check("t2_src1",  rsif.iss_src1_o,       64'hC);
    check("t2_src2",  rsif.iss_src2_o,       64'hD);
    check("t2_tag",   64'(rsif.iss_tag_o),   64'd6);
    rsif.iss_ready_i = 1'b1;
    tick();
    check("t2_occ_after", 64'(occ), 64'd0);

    // Fill, wake youngest first, stall, then drain in age order.
    for (int k = 1; k <= 4; k++) begin
      set_idle(); rsif.iss_ready_i = 1'b0;
      dispatch(TW'(k), TW'(8 + k), 6'd0, '0, vv(64'(k)), CW'(48 + k));
      tick();
    end
    set_idle(); rsif.iss_ready_i = 1'b0;
    check("t3_full_ready", 64'(rsif.disp_ready_o), 64'd0);
    check("t3_full_occ",   64'(occ),               64'd4);
    dispatch(6'd9, 6'd0, 6'd0, vv(64'd1), vv(64'd2), 10'h3F);
    tick(); set_idle(); rsif.iss_ready_i = 1'b0;
    check("t3_reject_occ", 64'(occ), 64'd4);
    for (int k = 4; k >= 1; k--) begin
      cdb(TW'(8 + k), 64'h100 + 64'(k));
      tick(); set_idle(); rsif.iss_ready_i = 1'b0;
    end
    check("t3_hold0_tag",  64'(rsif.iss_tag_o), 64'd1);
    check("t3_hold0_src1", rsif.iss_src1_o,     64'h101);
    tick(); set_idle(); rsif.iss_ready_i = 1'b0;
    check("t3_hold1_tag",  64'(rsif.iss_tag_o), 64'd1);
    rsif.iss_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("t3_order_tag",  64'(rsif.iss_tag_o), 64'(k));
      check("t3_order_src1", rsif.iss_src1_o,     64'h100 + 64'(k));
      tick(); set_idle();
    end
    check("t3_drained", 64'(occ), 64'd0);

    // Dispatch while the producer broadcasts in the same cycle.
    dispatch(6'd5, 6'd7, 6'd0, '0, vv(64'h9), 10'h44);
    cdb(6'd7, 64'h5);
    tick(); set_idle();
    check("t4_valid", 64'(rsif.iss_valid_o), 64'd1);
    check("t4_src1",  rsif.iss_src1_o,       64'h5);
    check("t4_src2",  rsif.iss_src2_o,       64'h9);
    tick();
    check("t4_occ_after", 64'(occ), 64'd0);

    // Flush beats a simultaneous dispatch.
    rsif.iss_ready_i = 1'b0;
    dispatch(6'd10, 6'd20, 6'd0, '0, vv(64'd1), 10'h1);
    tick(); set_idle(); rsif.iss_ready_i = 1'b0;
    dispatch(6'd11, 6'd21, 6'd0, '0, vv(64'd2), 10'h2);
    tick(); set_idle(); rsif.iss_ready_i = 1'b0;
    check("t5_two_resident", 64'(occ), 64'd2);
    dispatch(6'd12, 6'd0, 6'd0, vv(64'd3), vv(64'd4), 10'h3);
    flush_i = 1'b1;
    tick(); set_idle();
    check("t5_flush_occ",   64'(occ),               64'd0);
    check("t5_flush_valid", 64'(rsif.iss_valid_o),  64'd0);
    check("t5_flush_ready", 64'(rsif.disp_ready_o), 64'd1);

    // Asynchronous reset in the middle of a cycle.
    rsif.iss_ready_i = 1'b0;
    dispatch(6'd13, 6'd0, 6'd0, vv(64'd3), vv(64'd4), 10'h5);
    tick(); set_idle(); rsif.iss_ready_i = 1'b0;
    check("t6_pre_valid", 64'(rsif.iss_valid_o), 64'd1);
    #2 reset_i = 1'b1;
    #1;
    check("t6_rst_valid", 64'(rsif.iss_valid_o),  64'd0);
    check("t6_rst_occ",   64'(occ),               64'd0);
    check("t6_rst_ready", 64'(rsif.disp_ready_o), 64'd1);
    check("t6_rst_tag",   64'(rsif.iss_tag_o),    64'd0);
    check("t6_rst_src1",  rsif.iss_src1_o,        64'd0);
    tick();
    reset_i = 1'b0;
    set_idle();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      set_idle();
      if ($urandom_range(0, 9) < 7) begin
        dispatch(TW'($urandom_range(1, 32)), TW'($urandom_range(0, 8)), TW'($urandom_range(0, 8)),
                 {1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)},
                 {1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)},
                 CW'($urandom));
      end
      if ($urandom_range(0, 1) == 1) cdb(TW'($urandom_range(0, 8)), {32'($urandom), 32'($urandom)});
      rsif.iss_ready_i = ($urandom_range(0, 9) < 6);
      flush_i = ($urandom_range(0, 49) == 0);
      tick();
    end

    set_idle();
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
